mult_share_arb: RTL and testbench

- Shares one combinational 3x3 unsigned multiplier (`multi`, ports A/B/P) among NREQ requesters.
- Round-robin arbitration, operand registering, result capture, and a tagged response with valid/ready.
- Sits between the requesting datapath blocks and a single `multi` instance in the parent; the arbiter drives A/B and samples P.

---
 rtl/mult_share_arb.sv | 165 ++++++++++++++++
 tb/tb_mult_share_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// ---------------------------------------------------------------------------
// mult_share_arb
// Shares one external combinational unsigned multiplier among NREQ
// requesters. A round-robin arbiter picks one request per idle cycle,
// registers its operands onto mul_a/mul_b, captures mul_p one cycle later
// and presents it as a tagged response under a valid/ready handshake.
//
// Optional feature (macro MULT_SHARE_ARB_ZERO_SKIP_EN): when defined, an
// accepted operation with a zero operand skips the multiply cycle and
// answers 0 one cycle after acceptance.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  per-requester request
//   req_a/b    flattened operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot accept (combinational, idle state only)
//   mul_a/b    registered operands to the shared multiplier
//   mul_p      product from the shared multiplier
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_id     index of the requester owning the result
//   rsp_p      captured product (2*WIDTH bits)
//   busy       high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module mult_share_arb #(
   parameter int WIDTH = 3,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_p,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]      rsp_p,
   output logic                    busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDW-1:0]   rr_ptr_r;
   logic [NREQ-1:0]  grant_s;
   logic [IDW-1:0]   grant_id_s;
   logic [IDW-1:0]   next_ptr_s;
   logic [IDW-1:0]   idx_s;
   logic             hit_s;
   logic             found_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;
`ifdef MULT_SHARE_ARB_ZERO_SKIP_EN
   logic             zero_op_s;
`endif

   // Round-robin pick: first valid requester scanning from rr_ptr_r upward.
   always_comb begin
      grant_s    = '0;
      grant_id_s = '0;
      found_s    = 1'b0;
      idx_s      = '0;
      hit_s      = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s          = IDW'((int'(rr_ptr_r) + k) % NREQ);
         hit_s          = req_valid[idx_s] & ~found_s;
         grant_s[idx_s] = grant_s[idx_s] | hit_s;
         grant_id_s     = hit_s ? idx_s : grant_id_s;
         found_s        = found_s | hit_s;
      end
   end

   // Operand mux for the granted requester and the post-grant pointer.
   always_comb begin
      sel_a_s = '0;
      sel_b_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_a_s = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
         sel_b_s = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      end
      next_ptr_s = (grant_id_s == IDW'(NREQ - 1)) ? '0 : grant_id_s + 1'b1;
   end

`ifdef MULT_SHARE_ARB_ZERO_SKIP_EN
   // Zero-operand detect for the multiply bypass.
   always_comb begin
      zero_op_s = (sel_a_s == '0) || (sel_b_s == '0);
   end
`endif

   // Accept is offered only while idle and never during reset.
   always_comb begin
      if ((state_r == IDLE) && !rst) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
   end

   // Control FSM with registered datapath outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         rr_ptr_r  <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_p     <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  mul_a    <= sel_a_s;
                  mul_b    <= sel_b_s;
                  rsp_id   <= grant_id_s;
                  rr_ptr_r <= next_ptr_s;
                  busy     <= 1'b1;
`ifdef MULT_SHARE_ARB_ZERO_SKIP_EN
                  if (zero_op_s) begin
                     rsp_p     <= '0;
                     rsp_valid <= 1'b1;
                     state_r   <= RESP;
                  end else begin
                     state_r   <= CALC;
                  end
`else
                  state_r  <= CALC;
`endif
               end
            end
            CALC: begin
               // mul_p has settled from the registered operands.
               rsp_p     <= mul_p;
               rsp_valid <= 1'b1;
               state_r   <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arb.sv
// ---------------------------------------------------------------------------
// Testbench for mult_share_arb: directed scenarios followed by randomized
// traffic. Accepted operations are pushed into a scoreboard queue with the
// product computed arithmetically; a response monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_mult_share_arb;
   localparam int WIDTH = 3;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
`ifdef MULT_SHARE_ARB_ZERO_SKIP_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [2*WIDTH-1:0]    mul_p;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2*WIDTH-1:0]    rsp_p;
   logic                  busy;

   always #5 clk = ~clk;

   // The parent's shared multiplier.
   assign mul_p = {3'b000, mul_a} * {3'b000, mul_b};

   mult_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_p(rsp_p), .busy(busy)
   );

   typedef struct {
      int id;
      int a;
      int b;
      int p;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   outstanding = 0;
   int   exp_ptr = 0;
   bit   acc_evt = 1'b0;
   bit   rsp_evt = 1'b0;
   int   acc_id = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arbitration rule: first valid index scanning from ptr.
   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] v, input int ptr);
      logic [NREQ-1:0] r;
      r = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) begin
            r[(ptr + k) % NREQ] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   // Model state advance at each clock edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         q.delete();
         outstanding <= 0;
         exp_ptr     <= 0;
      end else if (acc_evt) begin
         outstanding <= 1;
         exp_ptr     <= (acc_id + 1) % NREQ;
      end else if (rsp_evt) begin
         outstanding <= 0;
      end
      acc_evt <= 1'b0;
      rsp_evt <= 1'b0;
   end

   // Request-side monitor: checks grants and pushes accepted operations.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] hs;
      int id, a, b;
      if (rst) begin
         chk("req_ready_rst", 32'(req_ready), 32'd0);
      end else begin
         exp_rdy = (outstanding != 0) ? '0 : rr_grant(req_valid, exp_ptr);
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(outstanding));
         hs = req_valid & req_ready;
         if (hs != '0) begin
            id = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (hs[i]) id = i;
            a = int'(req_a[id*WIDTH +: WIDTH]);
            b = int'(req_b[id*WIDTH +: WIDTH]);
            q.push_back('{id, a, b, a * b, cyc});
            acc_evt <= 1'b1;
            acc_id  <= id;
         end
      end
   end

   // Response monitor: latency, tag, product and hold-stable checks.
   always @(negedge clk) begin
      exp_t e;
      int lat;
      if (!rst) begin
         if (q.size() == 0) begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
         end else begin
            e   = q[0];
            lat = (ZS && (e.a == 0 || e.b == 0)) ? 1 : 2;
            if (cyc - e.cyc < lat) begin
               chk("rsp_early", 32'(rsp_valid), 32'd0);
            end else begin
               chk("rsp_valid", 32'(rsp_valid), 32'd1);
               if (rsp_valid) begin
                  chk("rsp_id", 32'(rsp_id), 32'(e.id));
                  chk("rsp_p", 32'(rsp_p), 32'(e.p));
                  if (rsp_ready) begin
                     void'(q.pop_front());
                     rsp_evt <= 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One cycle; requesters that were accepted drop their request.
   task automatic cycle_drop();
      logic [NREQ-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
      req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
      req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      step(2);
      @(negedge clk);
      chk("rst_mul_a", 32'(mul_a), 32'd0);
      chk("rst_mul_b", 32'(mul_b), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_p", 32'(rsp_p), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single operation.
      rsp_ready = 1'b1;
      set_op(0, 1, 3);
      cycle_drop();
      step(4);

      // All four at once, from a fresh pointer.
      do_reset();
      set_op(0, 5, 2);
      set_op(1, 3, 7);
      set_op(2, 1, 3);
      set_op(3, 7, 7);
      repeat (14) cycle_drop();

      // Two requesters held continuously.
      set_op(0, 2, 3);
      set_op(1, 4, 5);
      step(24);
      req_valid = '0;
      step(4);

      // Backpressure with competing requesters.
      set_op(2, 6, 5);
      rsp_ready = 1'b0;
      cycle_drop();
      set_op(0, 1, 1);
      set_op(3, 2, 7);
      step(5);
      rsp_ready = 1'b1;
      repeat (10) cycle_drop();

      // Zero operand.
      set_op(0, 0, 6);
      cycle_drop();
      step(4);

      // Reset in CALC, then in RESP.
      set_op(0, 3, 3);
      cycle_drop();
      do_reset();
      set_op(0, 3, 3);
      rsp_ready = 1'b0;
      cycle_drop();
      step(1);
      do_reset();
      rsp_ready = 1'b1;
      set_op(1, 2, 2);
      set_op(3, 5, 1);
      repeat (8) cycle_drop();

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         req_valid = NREQ'($urandom());
         req_a = (NREQ*WIDTH)'($urandom());
         req_b = (NREQ*WIDTH)'($urandom());
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 7) == 0) req_a[i*WIDTH +: WIDTH] = '0;
            if ($urandom_range(0, 7) == 0) req_b[i*WIDTH +: WIDTH] = '0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end

      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      step(6);
      chk("drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
